// File: rtl/vend_pkg.sv
// Shared state encoding for the vending controller.
package vend_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    ACCEPT   = 3'd1,
    CHECK    = 3'd2,
    DISPENSE = 3'd3,
    CHANGE   = 3'd4
  } state_e;

endpackage

// File: rtl/vend_ctrl_fsm_if.sv
// Coin-acceptor / dispenser / hopper signal bundle around the vending FSM.
interface vend_ctrl_fsm_if #(
  parameter int CREDIT_W = 8
);
  logic                coin;
  logic [CREDIT_W-1:0] coin_val;
  logic                check;
  logic                cancel;
  logic                dispense_ack;
  logic                change_ack;
  logic [2:0]          state;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amt;
  logic                coin_reject;
  logic                insufficient;

  modport master (
    output coin, coin_val, check, cancel, dispense_ack, change_ack,
    input  state, credit, dispense, change_valid, change_amt, coin_reject, insufficient
  );

  modport slave (
    input  coin, coin_val, check, cancel, dispense_ack, change_ack,
    output state, credit, dispense, change_valid, change_amt, coin_reject, insufficient
  );
endinterface

// File: rtl/vend_credit_acc.sv
// Credit register: overflow-checked add, price subtract and clear.
module vend_credit_acc #(
  parameter int CREDIT_W   = 8,
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 100
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                add_en_i,
  input  logic [CREDIT_W-1:0] add_val_i,
  input  logic                sub_en_i,
  input  logic                clr_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                ovf_o
);

  localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W:0]   sum;

  // One extra bit so a large coin cannot wrap below the ceiling.
  assign sum   = {1'b0, credit_q} + {1'b0, add_val_i};
  assign ovf_o = sum > MAX_C;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      credit_q <= '0;
    end else if (sub_en_i) begin
      credit_q <= credit_q - PRICE_C;
    end else if (add_en_i && !ovf_o) begin
      credit_q <= sum[CREDIT_W-1:0];
    end
  end

  assign credit_o = credit_q;

endmodule

// File: rtl/vend_ctrl_fsm.sv
// Vending controller: credit accumulation, price check, dispense and change handshakes.
module vend_ctrl_fsm #(
  parameter int CREDIT_W   = 8,
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 100
) (
  input logic            clk_i,
  input logic            rst_i,
  vend_ctrl_fsm_if.slave bus
);
  import vend_pkg::*;

  // state    | meaning
  // IDLE     | no credit, waiting for first coin
  // ACCEPT   | holding credit, taking coins / check / cancel
  // CHECK    | one-cycle price comparison
  // DISPENSE | dispense high until dispense_ack
  // CHANGE   | change_valid high until change_ack

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_e              state_q;
  logic                dispense_q, change_valid_q, coin_reject_q, insufficient_q;
  logic [CREDIT_W-1:0] change_amt_q;
  logic [CREDIT_W-1:0] credit;
  logic                coin_nz, can_pay, ovf;
  logic                add_en, sub_en, clr;

  assign coin_nz = bus.coin && (bus.coin_val != '0);
  assign can_pay = credit >= PRICE_C;

  always_comb begin
    add_en = 1'b0;
    sub_en = 1'b0;
    clr    = 1'b0;
    case (state_q)
      IDLE:     add_en = coin_nz;
      ACCEPT:   add_en = coin_nz && !bus.cancel && !bus.check;
      CHECK:    sub_en = can_pay;
      DISPENSE: clr    = 1'b0;
      CHANGE:   clr    = bus.change_ack;
      default:  clr    = 1'b1;
    endcase
  end

  vend_credit_acc #(
    .CREDIT_W   (CREDIT_W),
    .PRICE      (PRICE),
    .MAX_CREDIT (MAX_CREDIT)
  ) u_acc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .add_en_i  (add_en),
    .add_val_i (bus.coin_val),
    .sub_en_i  (sub_en),
    .clr_i     (clr),
    .credit_o  (credit),
    .ovf_o     (ovf)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (coin_nz) begin
            if (ovf) coin_reject_q <= 1'b1;
            else     state_q       <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (bus.cancel) begin
            state_q        <= CHANGE;
            change_valid_q <= 1'b1;
            change_amt_q   <= credit;
          end else if (bus.check) begin
            state_q <= CHECK;
          end else if (coin_nz && ovf) begin
            coin_reject_q <= 1'b1;
          end
        end
        CHECK: begin
          coin_reject_q <= coin_nz;
          if (can_pay) begin
            state_q    <= DISPENSE;
            dispense_q <= 1'b1;
          end else begin
            state_q        <= ACCEPT;
            insufficient_q <= 1'b1;
          end
        end
        DISPENSE: begin
          coin_reject_q <= coin_nz;
          if (bus.dispense_ack) begin
            dispense_q <= 1'b0;
            // credit already has PRICE removed; any remainder is change
            if (credit != '0) begin
              state_q        <= CHANGE;
              change_valid_q <= 1'b1;
              change_amt_q   <= credit;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        CHANGE: begin
          coin_reject_q <= coin_nz;
          if (bus.change_ack) begin
            state_q        <= IDLE;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
          end
        end
        default: begin
          state_q        <= IDLE;
          dispense_q     <= 1'b0;
          change_valid_q <= 1'b0;
          change_amt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.state        = state_q;
  assign bus.credit       = credit;
  assign bus.dispense     = dispense_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_amt   = change_amt_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.insufficient = insufficient_q;

endmodule
